// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter: round-robin grant of one byte at a time to a shared
// transmitter, with per-requester packet lock, inter-byte gap and busy timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int BSY_TIMEOUT = 16
) (
  input  logic                 clk_100mhz,
  input  logic                 rst_n_sync,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_hold,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 send_trig,
  output logic [7:0]           send_data,
  input  logic                 tx_bsy,
  output logic                 tx_err,
  output logic                 arb_busy
);

  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (BSY_TIMEOUT > GAP_CYCLES) ? BSY_TIMEOUT : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0]      BSY_LAST = CW'(BSY_TIMEOUT - 1);
  localparam logic [CW-1:0]      GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW-1:0]      PTR_RST  = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BSY = 2'd1,
    S_BUSY     = 2'd2,
    S_GAP      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 lock_valid_q, lock_valid_d;
  logic [PW-1:0]        lock_idx_q, lock_idx_d;
  logic                 send_trig_q, send_trig_d;
  logic [7:0]           send_data_q, send_data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_err_q, tx_err_d;
  logic                 arb_busy_q, arb_busy_d;

  logic                 rr_hit_s;
  logic [PW-1:0]        rr_idx_s;
  logic [PW-1:0]        cand_s;
  logic                 gnt_s;
  logic [PW-1:0]        gnt_idx_s;
  logic                 lock_drop_s;
  logic [7:0]           gnt_data_s;

  // Candidate selection; the descending scan leaves the nearest index after ptr.
  always_comb begin
    rr_hit_s = 1'b0;
    rr_idx_s = '0;
    cand_s   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s   = PW'((int'(ptr_q) + k) % NUM_REQ);
      rr_hit_s = rr_hit_s | req[cand_s];
      rr_idx_s = req[cand_s] ? cand_s : rr_idx_s;
    end
    lock_drop_s = 1'b0;
    if (lock_valid_q) begin
      gnt_idx_s   = lock_idx_q;
      gnt_s       = req[lock_idx_q];
      lock_drop_s = ~req[lock_idx_q] & ~req_hold[lock_idx_q];
    end else begin
      gnt_idx_s = rr_idx_s;
      gnt_s     = rr_hit_s;
    end
    gnt_data_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_data_s = (gnt_idx_s == PW'(i)) ? req_data[8*i +: 8] : gnt_data_s;
    end
  end

  // Next-state and output computation for the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    send_data_d  = send_data_q;
    send_trig_d  = 1'b0;
    ack_d        = '0;
    tx_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (gnt_s) begin
          state_d      = S_WAIT_BSY;
          send_trig_d  = 1'b1;
          send_data_d  = gnt_data_s;
          ack_d        = ONE_HOT0 << gnt_idx_s;
          ptr_d        = gnt_idx_s;
          lock_valid_d = req_hold[gnt_idx_s];
          lock_idx_d   = gnt_idx_s;
        end else if (lock_drop_s) begin
          lock_valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_BSY: begin
        if (tx_bsy) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end else if (cnt_q == BSY_LAST) begin
          state_d  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          tx_err_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BUSY: begin
        if (!tx_bsy) begin
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          cnt_d   = '0;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    arb_busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any byte in flight.
  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ptr_q        <= PTR_RST;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      send_trig_q  <= 1'b0;
      send_data_q  <= 8'h00;
      ack_q        <= '0;
      tx_err_q     <= 1'b0;
      arb_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      send_trig_q  <= send_trig_d;
      send_data_q  <= send_data_d;
      ack_q        <= ack_d;
      tx_err_q     <= tx_err_d;
      arb_busy_q   <= arb_busy_d;
    end
  end

  assign ack       = ack_q;
  assign send_trig = send_trig_q;
  assign send_data = send_data_q;
  assign tx_err    = tx_err_q;
  assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters and a transmitter model are
// driven from $urandom and every cycle is compared against a timeline model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int GAP_CYCLES  = 4;
  localparam int BSY_TIMEOUT = 16;
  localparam int NCYC        = 6000;

  logic                 clk_100mhz = 1'b0;
  logic                 rst_n_sync;
  logic [NUM_REQ-1:0]   req, req_hold, ack;
  logic [NUM_REQ*8-1:0] req_data;
  logic                 send_trig, tx_bsy, tx_err, arb_busy;
  logic [7:0]           send_data;

  int checks = 0;
  int errors = 0;

  // Timeline model: when the arbiter samples again and which cycles carry pulses.
  int   cyc;
  int   idle_from;
  int   exp_trig_cyc, exp_err_cyc, exp_sel;
  logic [7:0] exp_data, last_data;
  int   bsy_from, bsy_to;
  bit   lock_v;
  int   lock_i, last_sel, upd_idx;
  bit   rst_done;

  always #5 clk_100mhz = ~clk_100mhz;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP_CYCLES),
    .BSY_TIMEOUT(BSY_TIMEOUT)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst_n_sync(rst_n_sync),
    .req       (req),
    .req_hold  (req_hold),
    .req_data  (req_data),
    .ack       (ack),
    .send_trig (send_trig),
    .send_data (send_data),
    .tx_bsy    (tx_bsy),
    .tx_err    (tx_err),
    .arb_busy  (arb_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check_val({tag, "_trig"}, send_trig, 0);
    check_val({tag, "_ack"}, ack, 0);
    check_val({tag, "_err"}, tx_err, 0);
    check_val({tag, "_busy"}, arb_busy, 0);
    check_val({tag, "_data"}, send_data, 0);
  endtask

  task automatic check_cycle();
    logic [NUM_REQ-1:0] ack_exp;
    ack_exp = '0;
    if (cyc == exp_trig_cyc) begin
      ack_exp[exp_sel] = 1'b1;
      last_data        = exp_data;
    end
    check_val("send_trig", send_trig, cyc == exp_trig_cyc);
    check_val("ack", ack, ack_exp);
    check_val("tx_err", tx_err, cyc == exp_err_cyc);
    check_val("arb_busy", arb_busy, cyc < idle_from);
    check_val("send_data", send_data, last_data);
  endtask

  task automatic drive_inputs();
    if (upd_idx >= 0) begin
      req[upd_idx]             = ($urandom_range(0, 2) != 0);
      req_hold[upd_idx]        = req[upd_idx] & ($urandom_range(0, 2) == 0);
      req_data[8*upd_idx +: 8] = 8'($urandom);
      upd_idx = -1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req[i] && $urandom_range(0, 15) == 0) begin
        req[i]             = 1'b1;
        req_hold[i]        = ($urandom_range(0, 3) == 0);
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
    tx_bsy = (cyc >= bsy_from) && (cyc <= bsy_to);
  endtask

  task automatic model_step();
    int sel, t, d, len;
    sel = -1;
    if (cyc >= idle_from) begin
      if (lock_v) begin
        if (req[lock_i]) sel = lock_i;
        else if (!req_hold[lock_i]) lock_v = 1'b0;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++)
          if (sel < 0 && req[(last_sel + k) % NUM_REQ]) sel = (last_sel + k) % NUM_REQ;
      end
      if (sel >= 0) begin
        t            = cyc + 1;
        exp_sel      = sel;
        exp_data     = req_data[8*sel +: 8];
        exp_trig_cyc = t;
        last_sel     = sel;
        lock_v       = req_hold[sel];
        lock_i       = sel;
        upd_idx      = sel;
        if ($urandom_range(0, 5) == 0) begin
          bsy_from    = -1;
          bsy_to      = -2;
          exp_err_cyc = t + BSY_TIMEOUT;
          idle_from   = t + BSY_TIMEOUT + GAP_CYCLES;
        end else begin
          d   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BSY_TIMEOUT - 1) : $urandom_range(1, 3);
          len = $urandom_range(1, 12);
          bsy_from    = t + d;
          bsy_to      = t + d + len - 1;
          exp_err_cyc = -1;
          idle_from   = t + d + len + GAP_CYCLES + 1;
        end
      end
    end
  endtask

  task automatic do_reset(input bit immediate);
    rst_n_sync = 1'b0;
    tx_bsy     = 1'b0;
    if (immediate) begin
      #1;
      check_rst("rst_async");
    end
    repeat (3) @(posedge clk_100mhz);
    #1;
    check_rst("rst_hold");
    req      = '1;
    req_hold = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'($urandom);
    lock_v       = 1'b0;
    lock_i       = 0;
    last_sel     = NUM_REQ - 1;
    exp_trig_cyc = -1;
    exp_err_cyc  = -1;
    bsy_from     = -1;
    bsy_to       = -2;
    last_data    = 8'h00;
    upd_idx      = -1;
    cyc++;
    idle_from    = cyc;
    rst_n_sync   = 1'b1;
  endtask

  initial begin
    req        = '0;
    req_hold   = '0;
    req_data   = '0;
    tx_bsy     = 1'b0;
    rst_n_sync = 1'b0;
    cyc        = 0;
    rst_done   = 1'b0;
    do_reset(1'b0);
    model_step();
    while (cyc < NCYC) begin
      @(posedge clk_100mhz);
      #1;
      cyc++;
      check_cycle();
      if (!rst_done && ((cyc >= 2000 && lock_v && cyc > bsy_from && cyc <= bsy_to) || cyc >= 5000)) begin
        rst_done = 1'b1;
        do_reset(1'b1);
      end else begin
        drive_inputs();
      end
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
